// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared widths, sequencer state type and the saturating
//                increment used by the cache miss-handling logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int CACHE_DATA_WIDTH   = 32;
    localparam int CACHE_TAG_WIDTH    = 27;
    localparam int CACHE_SET_WIDTH    = 3;
    localparam int CACHE_OFFSET_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        FILL      = 2'd3
    } cache_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller_if
//  Description : CPU, cache-array and main-memory signals of the miss
//                sequencer; master = controller view, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_controller_if
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = CACHE_DATA_WIDTH
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic                  cpu_stall;

    logic                  cache_hit;
    logic                  victim_dirty;
    logic [DATA_WIDTH-1:0] victim_addr;
    logic [DATA_WIDTH-1:0] victim_data;
    logic                  cache_we;
    logic                  cache_fill;
    logic [DATA_WIDTH-1:0] fill_data;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cache_hit, victim_dirty,
               victim_addr, victim_data, mem_rdata, mem_ready,
        output cpu_stall, cache_we, cache_fill, fill_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cache_hit, victim_dirty,
               victim_addr, victim_data, mem_rdata, mem_ready,
        input  cpu_stall, cache_we, cache_fill, fill_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/cache_stats.sv
`default_nettype none
// ============================================================================
//  Module      : cache_stats
//  Description : Hit / miss / write-back event counters, saturating at all
//                ones. Only instantiated when CACHE_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_stats
    import cache_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_hit_inc,
    input  wire logic        i_miss_inc,
    input  wire logic        i_wb_inc,
    output logic [31:0]      o_hit_count,
    output logic [31:0]      o_miss_count,
    output logic [31:0]      o_wb_count
);

    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic [31:0] r_wb_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
            r_wb_count   <= 32'd0;
        end else begin
            if (i_hit_inc)  r_hit_count  <= sat_inc(r_hit_count);
            if (i_miss_inc) r_miss_count <= sat_inc(r_miss_count);
            if (i_wb_inc)   r_wb_count   <= sat_inc(r_wb_count);
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
    assign o_wb_count   = r_wb_count;

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller
//  Description : Miss-handling sequencer for the two-way data cache: hit
//                service, optional dirty write-back, refill and fill pulse.
//                Define CACHE_STATS_EN to build the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH   = CACHE_DATA_WIDTH,
    parameter int TAG_WIDTH    = CACHE_TAG_WIDTH,
    parameter int SET_WIDTH    = CACHE_SET_WIDTH,
    parameter int OFFSET_WIDTH = CACHE_OFFSET_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cache_controller_if.master  bus,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
    output logic [31:0]         wb_count
);

    cache_state_t          r_state, w_next_state;
    logic                  r_mem_req,   w_mem_req;
    logic                  r_mem_we,    w_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr,  w_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
    logic [DATA_WIDTH-1:0] r_fill_data, w_fill_data;
    logic [DATA_WIDTH-1:0] r_miss_addr, w_miss_addr;
    logic                  r_cache_fill, w_cache_fill;
    logic [DATA_WIDTH-1:0] w_line_addr;
    logic                  w_idle_hit;
    logic                  w_unused_offset;

    // One word per line, so the line address just clears the byte offset.
    assign w_line_addr = {bus.cpu_addr[DATA_WIDTH-1 -: TAG_WIDTH],
                          bus.cpu_addr[OFFSET_WIDTH +: SET_WIDTH],
                          {OFFSET_WIDTH{1'b0}}};
    assign w_unused_offset = ^bus.cpu_addr[OFFSET_WIDTH-1:0];

    assign w_idle_hit = (r_state == IDLE) && bus.cpu_req && bus.cache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_fill_data  <= '0;
            r_miss_addr  <= '0;
            r_cache_fill <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_mem_req    <= w_mem_req;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_fill_data  <= w_fill_data;
            r_miss_addr  <= w_miss_addr;
            r_cache_fill <= w_cache_fill;
        end
    end

    // Memory-side outputs are computed one state ahead so they are already
    // registered and stable during the state that owns the request.
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = r_mem_req;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_fill_data  = r_fill_data;
        w_miss_addr  = r_miss_addr;
        w_cache_fill = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cpu_req && !bus.cache_hit) begin
                    w_miss_addr = w_line_addr;
                    w_mem_req   = 1'b1;
                    if (bus.victim_dirty) begin
                        w_next_state = WRITEBACK;
                        w_mem_we     = 1'b1;
                        w_mem_addr   = bus.victim_addr;
                        w_mem_wdata  = bus.victim_data;
                    end else begin
                        w_next_state = REFILL;
                        w_mem_we     = 1'b0;
                        w_mem_addr   = w_line_addr;
                    end
                end
            end
            WRITEBACK: begin
                if (bus.mem_ready) begin
                    w_next_state = REFILL;
                    w_mem_we     = 1'b0;
                    w_mem_addr   = r_miss_addr;
                end
            end
            REFILL: begin
                if (bus.mem_ready) begin
                    w_next_state = FILL;
                    w_mem_req    = 1'b0;
                    w_fill_data  = bus.mem_rdata;
                    w_cache_fill = 1'b1;
                end
            end
            FILL:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.cpu_stall  = bus.cpu_req && !((r_state == IDLE) && bus.cache_hit);
    assign bus.cache_we   = w_idle_hit && bus.cpu_we;
    assign bus.cache_fill = r_cache_fill;
    assign bus.fill_data  = r_fill_data;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

`ifdef CACHE_STATS_EN
    logic w_miss_inc;
    logic w_wb_inc;

    assign w_miss_inc = (r_state == IDLE) && bus.cpu_req && !bus.cache_hit;
    assign w_wb_inc   = (r_state == WRITEBACK) && bus.mem_ready;

    cache_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .i_hit_inc    (w_idle_hit),
        .i_miss_inc   (w_miss_inc),
        .i_wb_inc     (w_wb_inc),
        .o_hit_count  (hit_count),
        .o_miss_count (miss_count),
        .o_wb_count   (wb_count)
    );
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
    assign wb_count   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_controller
//  Description : Directed self-checking bench for the cache miss sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

`ifdef CACHE_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] wb_count;

    int n_checks;
    int n_fails;
    int stalls;

    cache_controller_if bus ();

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        bus.cpu_req      = 1'b0;
        bus.cpu_we       = 1'b0;
        bus.cpu_addr     = 32'h0;
        bus.cache_hit    = 1'b0;
        bus.victim_dirty = 1'b0;
        bus.victim_addr  = 32'h0;
        bus.victim_data  = 32'h0;
        bus.mem_rdata    = 32'h0;
        bus.mem_ready    = 1'b0;

        // Reset state
        repeat (2) step();
        #1;
        check("rst_mem_req",    32'(bus.mem_req),    32'd0);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check("rst_mem_addr",   bus.mem_addr,        32'h0);
        check("rst_mem_wdata",  bus.mem_wdata,       32'h0);
        check("rst_fill_data",  bus.fill_data,       32'h0);
        check("rst_cache_fill", 32'(bus.cache_fill), 32'd0);
        check("rst_hit_count",  hit_count,           32'd0);
        check("rst_miss_count", miss_count,          32'd0);
        check("rst_wb_count",   wb_count,            32'd0);
        step();
        rst = 1'b0;

        // Hit on 0x40
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40; bus.cache_hit = 1'b1;
        #1;
        check("hit_stall",    32'(bus.cpu_stall), 32'd0);
        check("hit_mem_req",  32'(bus.mem_req),   32'd0);
        check("hit_cache_we", 32'(bus.cache_we),  32'd0);
        step();
        bus.cpu_req = 1'b0; bus.cache_hit = 1'b0;
        #1;
        check("hit_count1", hit_count, 32'(1*S));

        // Clean load miss on 0x80 (address byte offset bits ignored)
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h83;
        bus.victim_dirty = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("clean_c1_stall",   32'(bus.cpu_stall), 32'd1);
        check("clean_c1_mem_req", 32'(bus.mem_req),   32'd0);
        step();
        #1;
        check("clean_refill_stall",   32'(bus.cpu_stall), 32'd1);
        check("clean_refill_mem_req", 32'(bus.mem_req),   32'd1);
        check("clean_refill_mem_we",  32'(bus.mem_we),    32'd0);
        check("clean_refill_addr",    bus.mem_addr,       32'h80);
        step();
        #1;
        check("clean_fill_pulse", 32'(bus.cache_fill), 32'd1);
        check("clean_fill_data",  bus.fill_data,       32'hDEAD_BEEF);
        check("clean_fill_stall", 32'(bus.cpu_stall),  32'd1);
        check("clean_fill_req",   32'(bus.mem_req),    32'd0);
        step();
        bus.cache_hit = 1'b1;
        #1;
        check("clean_retry_stall", 32'(bus.cpu_stall),  32'd0);
        check("clean_retry_fill",  32'(bus.cache_fill), 32'd0);
        step();
        bus.cpu_req = 1'b0; bus.cache_hit = 1'b0;
        #1;
        check("clean_hit_count",  hit_count,  32'(2*S));
        check("clean_miss_count", miss_count, 32'(1*S));

        // Dirty store miss: write back 0x100, refill 0x200
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h200;
        bus.victim_dirty = 1'b1; bus.victim_addr = 32'h100; bus.victim_data = 32'h1234_5678;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        #1;
        check("dirty_c1_stall",    32'(bus.cpu_stall), 32'd1);
        check("dirty_c1_cache_we", 32'(bus.cache_we),  32'd0);
        step();
        // Victim inputs move on; the latched write-back must not follow them.
        bus.victim_dirty = 1'b0; bus.victim_addr = 32'hFFF0; bus.victim_data = 32'h0;
        #1;
        check("dirty_wb_req",   32'(bus.mem_req),   32'd1);
        check("dirty_wb_we",    32'(bus.mem_we),    32'd1);
        check("dirty_wb_addr",  bus.mem_addr,       32'h100);
        check("dirty_wb_wdata", bus.mem_wdata,      32'h1234_5678);
        check("dirty_wb_stall", 32'(bus.cpu_stall), 32'd1);
        step();
        #1;
        check("dirty_refill_req",  32'(bus.mem_req), 32'd1);
        check("dirty_refill_we",   32'(bus.mem_we),  32'd0);
        check("dirty_refill_addr", bus.mem_addr,     32'h200);
        step();
        #1;
        check("dirty_fill_pulse", 32'(bus.cache_fill), 32'd1);
        check("dirty_fill_data",  bus.fill_data,       32'hCAFE_F00D);
        check("dirty_fill_we",    32'(bus.cache_we),   32'd0);
        step();
        bus.cache_hit = 1'b1;
        #1;
        check("dirty_retry_stall", 32'(bus.cpu_stall),  32'd0);
        check("dirty_retry_we",    32'(bus.cache_we),   32'd1);
        check("dirty_retry_fill",  32'(bus.cache_fill), 32'd0);
        step();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cache_hit = 1'b0;
        #1;
        check("dirty_hit_count",  hit_count,  32'(3*S));
        check("dirty_miss_count", miss_count, 32'(2*S));
        check("dirty_wb_count",   wb_count,   32'(1*S));

        // Slow memory: mem_ready low for 5 REFILL cycles
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            bus.cpu_req      = 1'b1;
            bus.cpu_addr     = 32'h300;
            bus.victim_dirty = 1'b0;
            bus.mem_rdata    = 32'h0BAD_F00D;
            bus.mem_ready    = (k >= 6);
            bus.cache_hit    = (k >= 8);
            #1;
            if (k >= 1 && k <= 6) begin
                check("slow_mem_req",  32'(bus.mem_req), 32'd1);
                check("slow_mem_addr", bus.mem_addr,     32'h300);
            end
            if (!bus.cpu_stall) break;
            stalls++;
        end
        check("slow_stall_total", 32'(stalls), 32'd8);
        check("slow_fill_data",   bus.fill_data, 32'h0BAD_F00D);
        step();
        bus.cpu_req = 1'b0; bus.cache_hit = 1'b0;
        #1;
        check("slow_miss_count", miss_count, 32'(3*S));

        // Reset in the middle of REFILL
        step();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h400; bus.mem_ready = 1'b0;
        step();
        #1;
        check("rstmid_refill_req", 32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_mem_req",  32'(bus.mem_req), 32'd0);
        check("rstmid_mem_addr", bus.mem_addr,     32'h0);
        check("rstmid_hits",     hit_count,        32'd0);
        check("rstmid_misses",   miss_count,       32'd0);
        check("rstmid_wbs",      wb_count,         32'd0);
        step();
        rst = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        #1;
        check("rstmid_idle_stall", 32'(bus.cpu_stall), 32'd1);
        check("rstmid_idle_req",   32'(bus.mem_req),   32'd0);
        step();
        #1;
        check("rstmid_re_req",  32'(bus.mem_req), 32'd1);
        check("rstmid_re_addr", bus.mem_addr,     32'h400);
        step();
        #1;
        check("rstmid_fill_data", bus.fill_data, 32'h5555_AAAA);
        step();
        bus.cache_hit = 1'b1;
        #1;
        check("rstmid_retry_stall", 32'(bus.cpu_stall), 32'd0);
        step();
        bus.cpu_req = 1'b0; bus.cache_hit = 1'b0;
        #1;
        check("rstmid_miss_count", miss_count, 32'(1*S));
        check("rstmid_hit_count",  hit_count,  32'(1*S));

`ifdef CACHE_STATS_EN
        // Saturation: preset hit counter to all ones, then hit once more
        step();
        force dut.u_stats.r_hit_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_stats.r_hit_count;
        bus.cpu_req = 1'b1; bus.cache_hit = 1'b1; bus.cpu_addr = 32'h40;
        step();
        bus.cpu_req = 1'b0; bus.cache_hit = 1'b0;
        #1;
        check("sat_hit_count", hit_count, 32'hFFFF_FFFF);
`else
        check("nostats_hit_count", hit_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
# cache_controller

Miss-handling sequencer for the two-way set-associative data cache in front of `DataMemory`. It turns a CPU load/store into a hit service, or into an optional dirty-victim write-back followed by a line refill, over a request/ready handshake to main memory. It stalls the CPU until the access completes. It owns no data arrays: the cache supplies the hit and victim information, and the controller drives the fill and write enables.

## Interface
- `DATA_WIDTH`, 32, data and address width
- `TAG_WIDTH`, 27, tag bits of the address
- `SET_WIDTH`, 3, set index bits
- `OFFSET_WIDTH`, 2, byte offset bits (one word per line)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `cpu_req` in 1: CPU access valid this cycle
- `cpu_we` in 1: 1 = store, 0 = load
- `cpu_addr` in DATA_WIDTH: byte address; the CPU holds it stable while `cpu_stall`=1
- `cpu_stall` out 1: CPU must hold its request
- `cache_hit` in 1: cache lookup hit for `cpu_addr`
- `victim_dirty` in 1: the LRU way of the addressed set is valid and dirty
- `victim_addr` in DATA_WIDTH: line address of the dirty victim
- `victim_data` in DATA_WIDTH: data of the dirty victim
- `cache_we` out 1: write `cpu_wdata` into the hit way (store hit)
- `cache_fill` out 1: one-cycle pulse to install `fill_data` into the LRU way
- `fill_data` out DATA_WIDTH: registered refill word
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out DATA_WIDTH, `mem_wdata` out DATA_WIDTH: memory request
- `mem_rdata` in DATA_WIDTH, `mem_ready` in 1: memory response
- `hit_count`, `miss_count`, `wb_count` out 32 each: statistics (see Configuration)

## Operation
- States: IDLE, WRITEBACK, REFILL, FILL.
- IDLE
  - `cpu_req` and `cache_hit`: serve in the same cycle; `cache_we`=`cpu_we`; stay in IDLE.
  - `cpu_req` and not `cache_hit`: latch `miss_addr` = {tag, set, OFFSET_WIDTH'b0}.
  - Then go to WRITEBACK if `victim_dirty`, else to REFILL.
- WRITEBACK
  - Drives `mem_req`=1, `mem_we`=1, `mem_addr`=`victim_addr`, `mem_wdata`=`victim_data`, all latched on entry and held.
  - On `mem_ready`=1, go to REFILL.
- REFILL
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=`miss_addr`.
  - On `mem_ready`=1, capture `mem_rdata` into `fill_data` and go to FILL.
- FILL: `cache_fill`=1 for exactly one cycle, then return to IDLE. The held request is re-looked-up and hits.
- Write miss is write-allocate: refill first, then the store hits on retry and sets dirty.
- `cpu_stall` = `cpu_req` and not (state==IDLE and `cache_hit`). Combinational.
- `mem_req` holds with stable address and data until `mem_ready` is sampled high. `mem_ready` is ignored while `mem_req`=0.
- `cache_we` and `cache_fill` are never high in the same cycle. `cache_we` is 0 outside IDLE.
- Reset outputs: state=IDLE; `mem_req`, `mem_we`, `cache_we`, `cache_fill`=0; `mem_addr`, `mem_wdata`, `fill_data`, `miss_addr`=0; all counters=0.
- Reset asserted mid-transaction aborts immediately (asynchronously); `mem_req` drops without waiting for `mem_ready`. The memory side must tolerate the abandoned request.
- `cpu_req` deasserting mid-miss, which is a CPU protocol violation, does not abort the sequence; the line is still filled.

## Timing
- Hit: 0 stall cycles.
- Clean miss with `mem_ready` tied 1: stall in the miss cycle, REFILL, and FILL (3 cycles); the hit completes in cycle 4.
- Dirty miss with `mem_ready` tied 1: 4 stall cycles, since WRITEBACK adds 1.
- Each cycle of `mem_ready`=0 in WRITEBACK or REFILL adds one stall cycle.
- Every state output is registered except `cpu_stall` and `cache_we`, which are combinational from state and inputs.

## Configuration
- Macro: `CACHE_STATS_EN`.
- With the macro defined, the counters increment at these points. All saturate at 32'hFFFF_FFFF.
  - `hit_count`: once per IDLE cycle with `cpu_req` and `cache_hit`. FILL retry hits count.
  - `miss_count`: once per IDLE→WRITEBACK or IDLE→REFILL transition.
  - `wb_count`: once per WRITEBACK→REFILL transition.
- Without the macro: ports are present and tied to 0, and no counter flops are built.

## Structure
- Package `cache_pkg` holds:
  - the `cache_state_t` enum {IDLE, WRITEBACK, REFILL, FILL};
  - the width localparams (TAG/SET/OFFSET), shared with the cache and `cached_memory` top.
- One sub-module: `cache_stats`, the three saturating counters. It is instantiated only under `CACHE_STATS_EN`.

## Test plan
- Hit: preload the line; load 0x0000_0040 with `cache_hit`=1 → `cpu_stall`=0, no `mem_req`, `hit_count`=1.
- Clean load miss: 0x0000_0080, `cache_hit`=0, `victim_dirty`=0, `mem_ready`=1, `mem_rdata`=0xDEAD_BEEF → stall 3 cycles, `mem_addr`=0x80 with `mem_we`=0, `cache_fill` pulse with `fill_data`=0xDEAD_BEEF, then hit.
- Dirty store miss: `victim_dirty`=1, `victim_addr`=0x100, `victim_data`=0x1234_5678 → write 0x1234_5678 to 0x100, then refill the miss address, then `cache_we`=1; `wb_count`=1, `miss_count`=1.
- Slow memory: `mem_ready` low for 5 cycles in REFILL → `mem_req`, `mem_addr` stable throughout; stall totals 8 cycles.
- Reset mid-REFILL: assert `rst` between edges → `mem_req`=0 immediately, state IDLE, counters 0, the next request re-misses cleanly.
- Saturation (stats on): force `hit_count` to 0xFFFF_FFFF and then hit → the value stays 0xFFFF_FFFF. With the macro undefined, all counters read 0.
